// File: rtl/sram_pkg.sv
// Shared types and constants for the ZBT/NoBL SRAM device model.
// Used by sram_responder and sram_burst_addr (burst logic built with SRAM_RESP_BURST_EN).
package sram_pkg;

  localparam int unsigned SRAM_DATA_W  = 18;
  localparam int unsigned SRAM_LANE_W  = 9;
  localparam int unsigned SRAM_LANES   = SRAM_DATA_W / SRAM_LANE_W;
  localparam int unsigned SRAM_BURST_W = 2;
  localparam logic [2:0]  SRAM_CE_SEL  = 3'b010;

  typedef enum logic [1:0] {
    OP_DESEL = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } sram_op_e;

  // Per-stage command payload; the word address travels alongside it
  typedef struct packed {
    sram_op_e                op;
    logic [SRAM_LANES-1:0]   mask;
  } sram_cmd_t;

  localparam sram_cmd_t SRAM_CMD_IDLE = '{op: OP_DESEL, mask: '0};

  // Replace the lanes of old_word selected by mask with those of new_word
  function automatic logic [SRAM_DATA_W-1:0] lane_merge(
    input logic [SRAM_DATA_W-1:0] old_word,
    input logic [SRAM_DATA_W-1:0] new_word,
    input logic [SRAM_LANES-1:0]  mask
  );
    logic [SRAM_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(SRAM_LANES); i++) begin
      if (mask[i]) begin
        res[i*SRAM_LANE_W +: SRAM_LANE_W] = new_word[i*SRAM_LANE_W +: SRAM_LANE_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_burst_addr.sv
// Linear burst address generator: loads on a new command, wraps the low two
// address bits on advance, and flags an advance with no burst in progress.
module sram_burst_addr
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic              desel,
  input  logic              adv,
  input  sram_op_e          op_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              active,
  output sram_op_e          op,
  output logic [ADDR_W-1:0] next_addr_c,
  output logic              err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  sram_op_e          op_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              err_d;

  assign active      = (state_q == ST_BURST);
  assign next_addr_c = {addr_q[ADDR_W-1:SRAM_BURST_W],
                        addr_q[SRAM_BURST_W-1:0] + SRAM_BURST_W'(1)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op      <= OP_DESEL;
      addr_q  <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      op      <= op_d;
      addr_q  <= addr_d;
      err     <= err_d;
    end
  end

  // Stalled edges leave the burst untouched; err is sticky until reset
  always_comb begin
    state_d = state_q;
    op_d    = op;
    addr_d  = addr_q;
    err_d   = err;
    if (en) begin
      if (load) begin
        state_d = ST_BURST;
        op_d    = op_in;
        addr_d  = addr_in;
      end else if (desel) begin
        state_d = ST_IDLE;
      end else if (adv) begin
        if (state_q == ST_BURST) begin
          addr_d = next_addr_c;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Device-side model of the 18-bit ZBT/NoBL pipelined SRAM (two-edge read/write latency).
// Define SRAM_RESP_BURST_EN to enable linear bursts and the advance-without-load err flag.
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  sram_addr,
  inout  wire  [SRAM_DATA_W-1:0] sram_data,
  input  logic [1:0]             sram_bw,
  input  logic                   sram_advload,
  input  logic                   sram_we,
  input  logic [2:0]             sram_ce,
  input  logic                   sram_oe,
  input  logic                   sram_cen,
  output logic                   err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic                   en_c;
  logic                   sel_c;
  sram_cmd_t              new_cmd_c;
  logic [DEPTH_LOG2-1:0]  new_addr_c;
  logic                   addr_unused_c;

  sram_cmd_t              s1_cmd_q;
  logic [DEPTH_LOG2-1:0]  s1_addr_q;
  sram_cmd_t              s2_cmd_q;
  logic [DEPTH_LOG2-1:0]  s2_addr_q;
  logic [SRAM_DATA_W-1:0] s2_rdata_q;
  logic                   out_valid_q;
  logic [SRAM_DATA_W-1:0] out_data_q;

  logic                   wr_commit_c;
  logic [SRAM_DATA_W-1:0] fetch_c;

  logic [SRAM_DATA_W-1:0] mem [DEPTH];

  assign en_c          = ~sram_cen;
  assign sel_c         = (sram_ce == SRAM_CE_SEL);
  assign addr_unused_c = ^sram_addr[ADDR_WIDTH-1:DEPTH_LOG2];

`ifdef SRAM_RESP_BURST_EN
  logic                  burst_active;
  sram_op_e              burst_op;
  logic [DEPTH_LOG2-1:0] burst_next_addr_c;

  sram_burst_addr #(
    .ADDR_W (DEPTH_LOG2)
  ) u_burst (
    .clk         (clk),
    .reset       (reset),
    .en          (en_c),
    .load        (~sram_advload & sel_c),
    .desel       (~sram_advload & ~sel_c),
    .adv         (sram_advload),
    .op_in       (sram_we ? OP_READ : OP_WRITE),
    .addr_in     (sram_addr[DEPTH_LOG2-1:0]),
    .active      (burst_active),
    .op          (burst_op),
    .next_addr_c (burst_next_addr_c),
    .err         (err)
  );
`else
  assign err = 1'b0;
`endif

  // Command decode for the current edge; anything unrecognised is a bubble
  always_comb begin
    new_cmd_c  = SRAM_CMD_IDLE;
    new_addr_c = sram_addr[DEPTH_LOG2-1:0];
    if (!sram_advload) begin
      if (sel_c) begin
        new_cmd_c.op   = sram_we ? OP_READ : OP_WRITE;
        new_cmd_c.mask = sram_we ? '0 : ~sram_bw;
      end
    end
`ifdef SRAM_RESP_BURST_EN
    else if (burst_active) begin
      new_cmd_c.op   = burst_op;
      new_cmd_c.mask = (burst_op == OP_WRITE) ? ~sram_bw : '0;
      new_addr_c     = burst_next_addr_c;
    end
`endif
  end

  assign wr_commit_c = en_c && (s2_cmd_q.op == OP_WRITE);

  // Read fetch happens as s1 moves to s2; forward lanes committed on the same edge
  always_comb begin
    fetch_c = mem[s1_addr_q];
    if (wr_commit_c && (s2_addr_q == s1_addr_q)) begin
      fetch_c = lane_merge(fetch_c, sram_data, s2_cmd_q.mask);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_cmd_q    <= SRAM_CMD_IDLE;
      s1_addr_q   <= '0;
      s2_cmd_q    <= SRAM_CMD_IDLE;
      s2_addr_q   <= '0;
      s2_rdata_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en_c) begin
      s1_cmd_q    <= new_cmd_c;
      s1_addr_q   <= new_addr_c;
      s2_cmd_q    <= s1_cmd_q;
      s2_addr_q   <= s1_addr_q;
      s2_rdata_q  <= fetch_c;
      out_valid_q <= (s2_cmd_q.op == OP_READ);
      out_data_q  <= s2_rdata_q;
    end
  end

  // Array has no reset so contents survive it
  always_ff @(posedge clk) begin
    if (wr_commit_c) begin
      mem[s2_addr_q] <= lane_merge(mem[s2_addr_q], sram_data, s2_cmd_q.mask);
    end
  end

  assign sram_data = (out_valid_q && !sram_oe) ? out_data_q : {SRAM_DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder; the bus is pulled high so an undriven bus reads 0x3FFFF.
module tb_sram_responder;

  localparam logic [17:0] HIZ = 18'h3FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] sram_addr;
  tri1  [17:0] sram_data;
  logic [1:0]  sram_bw;
  logic        sram_advload;
  logic        sram_we;
  logic [2:0]  sram_ce;
  logic        sram_oe;
  logic        sram_cen;
  logic        err;

  logic        tb_drv_en;
  logic [17:0] tb_drv_val;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign sram_data = tb_drv_en ? tb_drv_val : 18'bz;

  sram_responder u_dut (
    .clk          (clk),
    .reset        (reset),
    .sram_addr    (sram_addr),
    .sram_data    (sram_data),
    .sram_bw      (sram_bw),
    .sram_advload (sram_advload),
    .sram_we      (sram_we),
    .sram_ce      (sram_ce),
    .sram_oe      (sram_oe),
    .sram_cen     (sram_cen),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
  endtask

  // One clock: inputs applied at negedge, outputs observable 1ns after posedge
  task automatic step(input logic adv, input logic we, input logic [2:0] ce, input logic [1:0] bw,
                      input logic [19:0] addr, input logic cen, input logic drv, input logic [17:0] dval);
    @(negedge clk);
    sram_advload = adv;
    sram_we      = we;
    sram_ce      = ce;
    sram_bw      = bw;
    sram_addr    = addr;
    sram_cen     = cen;
    tb_drv_en    = drv;
    tb_drv_val   = dval;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [19:0] a, input logic [1:0] bw);
    step(1'b0, 1'b0, 3'b010, bw, a, 1'b0, 1'b0, 18'h0);
  endtask
  task automatic rd(input logic [19:0] a);
    step(1'b0, 1'b1, 3'b010, 2'b11, a, 1'b0, 1'b0, 18'h0);
  endtask
  task automatic nop(input logic drv, input logic [17:0] d);
    step(1'b0, 1'b1, 3'b000, 2'b11, 20'h0, 1'b0, drv, d);
  endtask
  task automatic adv(input logic [1:0] bw, input logic drv, input logic [17:0] d);
    step(1'b1, 1'b1, 3'b000, bw, 20'h0, 1'b0, drv, d);
  endtask
  task automatic stall();
    step(1'b0, 1'b0, 3'b010, 2'b00, 20'h10, 1'b1, 1'b0, 18'h0);
  endtask

  initial begin
    reset = 1'b1; sram_addr = '0; sram_bw = 2'b11; sram_advload = 1'b0; sram_we = 1'b1;
    sram_ce = 3'b000; sram_oe = 1'b0; sram_cen = 1'b0; tb_drv_en = 1'b0; tb_drv_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus_hiz", sram_data, HIZ);
    chk("reset_err", {17'b0, err}, 18'd0);
    @(negedge clk) reset = 1'b0;

    // Basic write then read with latency checks
    wr(20'h00010, 2'b00); nop(1'b0, 0); nop(1'b1, 18'h155AA);
    rd(20'h00010);  chk("rd_lat_e0", sram_data, HIZ);
    nop(1'b0, 0);   chk("rd_lat_e1", sram_data, HIZ);
    nop(1'b0, 0);   chk("rd_data_e2", sram_data, 18'h155AA);
    nop(1'b0, 0);   chk("rd_release", sram_data, HIZ);

    // Byte-lane write: upper lane only
    wr(20'h00020, 2'b00); wr(20'h00020, 2'b01);
    nop(1'b1, 18'h3FFFF); nop(1'b1, 18'h00000);
    rd(20'h00020); nop(1'b0, 0); nop(1'b0, 0);
    chk("lane_upper", sram_data, 18'h001FF);

    // Forwarding: read fetch coincides with write commit
    wr(20'h00040, 2'b00); wr(20'h00041, 2'b00);
    nop(1'b1, 18'h11111); nop(1'b1, 18'h3FFFF);
    wr(20'h00040, 2'b00); rd(20'h00040); nop(1'b1, 18'h00ABC); nop(1'b0, 0);
    chk("fwd_full", sram_data, 18'h00ABC);
    wr(20'h00041, 2'b10); rd(20'h00041); nop(1'b1, 18'h00000); nop(1'b0, 0);
    chk("fwd_lane", sram_data, 18'h3FE00);
    rd(20'h00040); nop(1'b0, 0); nop(1'b0, 0);
    chk("array_after_fwd", sram_data, 18'h00ABC);
    nop(1'b0, 0);

    // Stalls do not count toward latency; oe is combinational
    rd(20'h00010); nop(1'b0, 0);
    stall(); stall(); stall();
    chk("stall_no_data", sram_data, HIZ);
    nop(1'b0, 0);   chk("stall_data", sram_data, 18'h155AA);
    sram_oe = 1'b1; #1; chk("oe_off", sram_data, HIZ);
    sram_oe = 1'b0; #1; chk("oe_on", sram_data, 18'h155AA);
    stall();        chk("stall_out_hold", sram_data, 18'h155AA);
    nop(1'b0, 0);   chk("out_release", sram_data, HIZ);

`ifdef SRAM_RESP_BURST_EN
    // Write burst with wrap, then individual reads
    wr(20'h00102, 2'b00); adv(2'b00, 1'b0, 0);
    adv(2'b00, 1'b1, 18'd1); adv(2'b00, 1'b1, 18'd2);
    nop(1'b1, 18'd3); nop(1'b1, 18'd4);
    rd(20'h00102); rd(20'h00103);
    rd(20'h00100); chk("bw_rd_0102", sram_data, 18'd1);
    rd(20'h00101); chk("bw_rd_0103", sram_data, 18'd2);
    nop(1'b0, 0);  chk("bw_rd_0100", sram_data, 18'd3);
    nop(1'b0, 0);  chk("bw_rd_0101", sram_data, 18'd4);
    chk("burst_no_err", {17'b0, err}, 18'd0);
    // Read burst over the same words
    rd(20'h00102); adv(2'b11, 1'b0, 0);
    adv(2'b11, 1'b0, 0); chk("br_0", sram_data, 18'd1);
    adv(2'b11, 1'b0, 0); chk("br_1", sram_data, 18'd2);
    nop(1'b0, 0);        chk("br_2", sram_data, 18'd3);
    nop(1'b0, 0);        chk("br_3", sram_data, 18'd4);
    nop(1'b0, 0);
`else
    // Without bursts an advance is a bubble
    rd(20'h00010); adv(2'b11, 1'b0, 0);
    nop(1'b0, 0);  chk("adv_rd_first", sram_data, 18'h155AA);
    nop(1'b0, 0);  chk("adv_is_desel", sram_data, HIZ);
    chk("adv_no_err", {17'b0, err}, 18'd0);
`endif

    // Async reset during a read burst
    rd(20'h00010); adv(2'b11, 1'b0, 0); nop(1'b0, 0);
    chk("pre_reset_data", sram_data, 18'h155AA);
    #2 reset = 1'b1;
    #1 chk("reset_async_hiz", sram_data, HIZ);
    @(negedge clk) reset = 1'b0;
    adv(2'b11, 1'b0, 0);
`ifdef SRAM_RESP_BURST_EN
    chk("adv_after_reset_err", {17'b0, err}, 18'd1);
`else
    chk("adv_after_reset_err", {17'b0, err}, 18'd0);
`endif
    rd(20'h00010); nop(1'b0, 0); nop(1'b0, 0);
    chk("array_kept", sram_data, 18'h155AA);
    nop(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
